// File: rtl/rom_pkg.sv
// Shared helpers for the read-only memory.
package rom_pkg;

   // True when a word address falls inside an array of the given depth.
   function automatic logic addr_in_range(input int unsigned a, input int unsigned depth);
      return a < depth;
   endfunction

endpackage

// File: rtl/rom.sv
// Synchronous-read ROM: registered address lookup, one cycle of read latency.
// Contents come from hierarchical writes to rom[].
module rom
   import rom_pkg::*;
#(
   parameter int unsigned Width    = 32,
   parameter int unsigned Depth    = 32,
   parameter string       InitFile = ""
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [$clog2(Depth)-1:0]   addr,
   output logic [Width-1:0]           data
);

   localparam int unsigned AddrWidth = $clog2(Depth);

   // Reject degenerate geometries at elaboration.
   if (Depth < 2 || Width < 1) begin : g_param_check
      $fatal(1, "rom: Depth must be >= 2 and Width >= 1");
   end

   // No reset and no write port: benches poke this array directly.
   logic [Width-1:0] rom [0:Depth-1];

   // Registered read; reset wins, and addresses past Depth-1 read as zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         data <= '0;
      end else if (addr_in_range(32'(addr), Depth)) begin
         data <= rom[addr];
      end else begin
         data <= '0;
      end
   end

   logic unused_addr_width;
   assign unused_addr_width = ^AddrWidth;

endmodule

// File: tb/tb_rom.sv
// Directed bench for rom: a 32-word instance and a 20-word instance with
// out-of-range addresses.
module tb_rom;

   logic        clk;
   logic        reset;
   logic [4:0]  addr;
   logic [31:0] data;
   logic [4:0]  addr20;
   logic [31:0] data20;

   int checks = 0;
   int errors = 0;

   rom #(.Width(32), .Depth(32), .InitFile("")) u_rom (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .data  (data)
   );

   rom #(.Width(32), .Depth(20), .InitFile("")) u_rom20 (
      .clk   (clk),
      .reset (reset),
      .addr  (addr20),
      .data  (data20)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and move to a point safely after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) u_rom.rom[i] = 32'(i + 1);
      for (int i = 0; i < 20; i++) u_rom20.rom[i] = 32'h0000_00A0 + 32'(i);

      // Reset state.
      reset  = 1'b1;
      addr   = 5'd3;
      addr20 = 5'd3;
      tick();
      chk("reset_data", data, 32'd0);
      chk("reset_data20", data20, 32'd0);

      // Sweep with one-cycle lag; first read at first edge with reset low.
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         addr = 5'(i);
         tick();
         chk($sformatf("sweep_%0d", i), data, 32'(i + 1));
      end

      // Held address re-reads the same word.
      tick();
      chk("hold31_a", data, 32'd32);
      tick();
      chk("hold31_b", data, 32'd32);

      // Mid-stream reset discards the addressed word.
      addr  = 5'd5;
      reset = 1'b1;
      tick();
      chk("rst_mid_a", data, 32'd0);
      tick();
      chk("rst_mid_b", data, 32'd0);
      reset = 1'b0;
      tick();
      chk("rst_release", data, 32'd6);

      // Alternate between the first and last words.
      for (int i = 0; i < 6; i++) begin
         addr = (i % 2 == 0) ? 5'd0 : 5'd31;
         tick();
         chk($sformatf("alt_%0d", i), data, (i % 2 == 0) ? 32'd1 : 32'd32);
      end

      // Hierarchical change under a held address shows up one edge later.
      addr = 5'd7;
      tick();
      chk("poke_before", data, 32'd8);
      u_rom.rom[7] = 32'hCAFE_F00D;
      tick();
      chk("poke_after", data, 32'hCAFE_F00D);

      // Non-power-of-two depth: out-of-range reads as zero, last word valid.
      addr20 = 5'd25;
      tick();
      chk("d20_addr25", data20, 32'd0);
      addr20 = 5'd19;
      tick();
      chk("d20_addr19", data20, 32'h0000_00B3);
      addr20 = 5'd20;
      tick();
      chk("d20_addr20", data20, 32'd0);
      addr20 = 5'd0;
      tick();
      chk("d20_addr0", data20, 32'h0000_00A0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
